// File: rtl/ahb_lite_interconnect.sv
// AHB-Lite single-master interconnect: address decode, registered data-phase slave mux,
// built-in default (ERROR) slave and per-slot stall watchdog with sticky fault isolation.
// Latency: zero added cycles for mapped slots; default/aborted transfers complete with a two-cycle ERROR.
// Backpressure: HREADYOUT mirrors the selected slot; a new address phase is accepted only while it is high.
//
// Ports:
//   HCLK, HRESET     bus clock, asynchronous active-high reset
//   HADDR, HTRANS    master address-phase signals
//   HSEL_A           one-hot slot select, combinational from HADDR
//   HREADYOUT_A, HRESP_A, HRDATA_A   per-slot data-phase returns (slot k data at [32k+31:32k])
//   HREADYOUT, HRESP, HRDATA         system data-phase returns to the master
//   FAULT            sticky per-slot timeout flags
//   ERR_COUNT        saturating count of interconnect-generated ERROR completions
module ahb_lite_interconnect #(
  parameter int unsigned DEVICES_EXP = 3,
  parameter int unsigned DEC_LSB     = 24,
  parameter logic [31:0] BASE_TAG    = 32'h0,
  parameter logic [(2**DEVICES_EXP)-1:0] SLOT_EN = '1,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                             HCLK,
  input  logic                             HRESET,
  input  logic [31:0]                      HADDR,
  input  logic [1:0]                       HTRANS,
  output logic [(2**DEVICES_EXP)-1:0]      HSEL_A,
  input  logic [(2**DEVICES_EXP)-1:0]      HREADYOUT_A,
  input  logic [(2**DEVICES_EXP)-1:0]      HRESP_A,
  input  logic [(2**DEVICES_EXP)*32-1:0]   HRDATA_A,
  output logic                             HREADYOUT,
  output logic                             HRESP,
  output logic [31:0]                      HRDATA,
  output logic [(2**DEVICES_EXP)-1:0]      FAULT,
  output logic [7:0]                       ERR_COUNT
);

  localparam int unsigned N       = 2**DEVICES_EXP;
  localparam int unsigned TAG_LSB = DEC_LSB + DEVICES_EXP;
  // Stall counter only needs to reach TIMEOUT-1; keep at least one bit when the watchdog is off.
  localparam int unsigned CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_C  = CW'(TIMEOUT);

  localparam logic [1:0] ST_DATA = 2'd0;
  localparam logic [1:0] ST_ERR1 = 2'd1;
  localparam logic [1:0] ST_ERR2 = 2'd2;

  logic [1:0]             state_q,   state_d;
  logic [DEVICES_EXP-1:0] dp_idx_q,  dp_idx_d;
  logic                   dp_hit_q,  dp_hit_d;
  logic                   dp_act_q,  dp_act_d;
  logic [CW-1:0]          cnt_q,     cnt_d;
  logic [N-1:0]           fault_q,   fault_d;
  logic [7:0]             err_cnt_q, err_cnt_d;

  logic [DEVICES_EXP-1:0] idx;
  logic                   tag_ok;
  logic                   hit;
  logic [CW-1:0]          cnt_inc;
  logic                   abort;
  logic [31:0]            rdata_arr [N];

  // Low address bits and HTRANS[0] play no part in routing.
  logic unused_bits;
  assign unused_bits = &{1'b0, HADDR[DEC_LSB-1:0], HTRANS[0]};

  // ---------------- address-phase decode ----------------
  assign idx    = HADDR[DEC_LSB +: DEVICES_EXP];
  assign tag_ok = (HADDR[31:TAG_LSB] == BASE_TAG[31-TAG_LSB:0]);
  // A faulted slot drops out of the map so the default slave answers for it.
  assign hit    = tag_ok && SLOT_EN[idx] && !fault_q[idx];

  always_comb begin
    HSEL_A = '0;
    if (hit) HSEL_A[idx] = 1'b1;
  end

  always_comb begin
    for (int k = 0; k < N; k++) rdata_arr[k] = HRDATA_A[32*k +: 32];
  end

  // ---------------- data-phase return mux ----------------
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    HRDATA    = 32'h0;
    case (state_q)
      ST_DATA: begin
        if (dp_act_q) begin
          if (dp_hit_q) begin
            HREADYOUT = HREADYOUT_A[dp_idx_q];
            HRESP     = HRESP_A[dp_idx_q];
            HRDATA    = rdata_arr[dp_idx_q];
          end else begin
            // Unreachable in practice: an active default phase is loaded straight into ERR1.
            HREADYOUT = 1'b0;
            HRESP     = 1'b1;
          end
        end
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      ST_ERR2: begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------- watchdog and state ----------------
  // cnt_q holds completed stall cycles; the abort fires in the TIMEOUT-th stall cycle
  // unless the slave raises ready in that same cycle.
  assign cnt_inc = cnt_q + 1'b1;
  assign abort   = (TIMEOUT != 0) && (cnt_inc == TO_C);

  always_comb begin
    state_d   = state_q;
    dp_idx_d  = dp_idx_q;
    dp_hit_d  = dp_hit_q;
    dp_act_d  = dp_act_q;
    cnt_d     = cnt_q;
    fault_d   = fault_q;
    err_cnt_d = err_cnt_q;

    case (state_q)
      ST_DATA: begin
        if (dp_act_q && dp_hit_q && !HREADYOUT_A[dp_idx_q]) begin
          if (abort) begin
            state_d           = ST_ERR1;
            fault_d[dp_idx_q] = 1'b1;
          end else if (TIMEOUT != 0) begin
            cnt_d = cnt_inc;
          end
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      ST_ERR2: begin
        state_d = ST_DATA;
        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      end
      default: state_d = ST_DATA;
    endcase

    // Address-phase capture; HREADYOUT is never high in an abort or ERR1 cycle,
    // so this never collides with the transitions above.
    if (HREADYOUT) begin
      dp_idx_d = idx;
      dp_hit_d = hit;
      dp_act_d = HTRANS[1];
      cnt_d    = '0;
      state_d  = (HTRANS[1] && !hit) ? ST_ERR1 : ST_DATA;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q   <= ST_DATA;
      dp_idx_q  <= '0;
      dp_hit_q  <= 1'b0;
      dp_act_q  <= 1'b0;
      cnt_q     <= '0;
      fault_q   <= '0;
      err_cnt_q <= 8'h0;
    end else begin
      state_q   <= state_d;
      dp_idx_q  <= dp_idx_d;
      dp_hit_q  <= dp_hit_d;
      dp_act_q  <= dp_act_d;
      cnt_q     <= cnt_d;
      fault_q   <= fault_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign FAULT     = fault_q;
  assign ERR_COUNT = err_cnt_q;

endmodule

// File: tb/tb_ahb_lite_interconnect.sv
// Bench for ahb_lite_interconnect: directed bus traffic with a transaction-level reference
// model (data-phase kind + age) checked on every negative clock edge, plus literal expectations.
module tb_ahb_lite_interconnect;

  localparam int          TO = 4;
  localparam logic [7:0]  EN = 8'hDF;   // slot 5 unpopulated

  logic         HCLK;
  logic         HRESET;
  logic [31:0]  HADDR;
  logic [1:0]   HTRANS;
  logic [7:0]   HSEL_A;
  logic [7:0]   HREADYOUT_A;
  logic [7:0]   HRESP_A;
  logic [255:0] HRDATA_A;
  logic         HREADYOUT;
  logic         HRESP;
  logic [31:0]  HRDATA;
  logic [7:0]   FAULT;
  logic [7:0]   ERR_COUNT;

  int total = 0;
  int bad   = 0;

  ahb_lite_interconnect #(
    .DEVICES_EXP(3), .DEC_LSB(24), .BASE_TAG(32'h0), .SLOT_EN(EN), .TIMEOUT(TO)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSEL_A(HSEL_A), .HREADYOUT_A(HREADYOUT_A), .HRESP_A(HRESP_A), .HRDATA_A(HRDATA_A),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .FAULT(FAULT), .ERR_COUNT(ERR_COUNT)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Data phase: kind 0 = idle, 1 = mapped slot, 2 = default slave; age = cycles spent in it.
  int         m_kind, m_slot, m_age, m_err;
  logic [7:0] m_fault;

  function automatic logic [7:0] dec(input logic [31:0] a);
    int i;
    i = int'(a[26:24]);
    if (a[31:27] == 5'd0 && EN[i] && !m_fault[i]) return 8'(1 << i);
    return 8'h00;
  endfunction

  always @(negedge HCLK) begin
    logic        e_rdy, e_resp;
    logic [31:0] e_dat;
    logic [7:0]  e_sel;
    if (HRESET) begin
      m_kind = 0; m_slot = 0; m_age = 0; m_err = 0; m_fault = 8'h00;
    end else begin
      // A slot stalled for TO cycles is aborted; its fault is visible from the first ERROR cycle.
      if (m_kind == 1 && m_age == TO) m_fault[m_slot] = 1'b1;
      e_rdy = 1'b1; e_resp = 1'b0; e_dat = 32'h0;
      if (m_kind == 2) begin
        e_rdy = (m_age == 1); e_resp = 1'b1;
      end else if (m_kind == 1) begin
        if (m_age < TO) begin
          e_rdy  = HREADYOUT_A[m_slot];
          e_resp = HRESP_A[m_slot];
          e_dat  = HRDATA_A[32*m_slot +: 32];
        end else begin
          e_rdy = (m_age == TO + 1); e_resp = 1'b1;
        end
      end
      e_sel = dec(HADDR);
      chk("m_hsel",  HSEL_A,    e_sel);
      chk("m_ready", HREADYOUT, e_rdy);
      chk("m_resp",  HRESP,     e_resp);
      chk("m_rdata", HRDATA,    e_dat);
      chk("m_fault", FAULT,     m_fault);
      chk("m_errc",  ERR_COUNT, m_err);
      if (e_rdy) begin
        if ((m_kind == 2 || (m_kind == 1 && m_age == TO + 1)) && m_err < 255) m_err++;
        m_age = 0;
        if (!HTRANS[1])         m_kind = 0;
        else if (e_sel != 8'h0) begin m_kind = 1; m_slot = int'(HADDR[26:24]); end
        else                    m_kind = 2;
      end else begin
        m_age++;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge HCLK); #1;
  endtask

  task automatic at_neg();
    @(negedge HCLK);
  endtask

  task automatic unmapped(input logic [31:0] a, input int exp_cnt, input string nm);
    HADDR = a; HTRANS = 2'b10;
    at_neg(); chk({nm, "_hsel"}, HSEL_A, 8'h00);
    step(); HTRANS = 2'b00; HADDR = 32'h0;
    at_neg(); chk({nm, "_e1rdy"}, HREADYOUT, 1'b0); chk({nm, "_e1resp"}, HRESP, 1'b1);
    step();
    at_neg(); chk({nm, "_e2rdy"}, HREADYOUT, 1'b1); chk({nm, "_e2resp"}, HRESP, 1'b1);
    step();
    at_neg(); chk({nm, "_cnt"}, ERR_COUNT, exp_cnt);
    step();
  endtask

  initial begin
    int done_at;
    HRESET = 1'b1; HADDR = 32'h0; HTRANS = 2'b00;
    HREADYOUT_A = 8'hFF; HRESP_A = 8'h00;
    for (int k = 0; k < 8; k++) HRDATA_A[32*k +: 32] = 32'hCAFE_0000 + k;

    // Reset held three cycles.
    repeat (3) @(posedge HCLK);
    at_neg();
    chk("rst_ready", HREADYOUT, 1'b1);
    chk("rst_resp",  HRESP,     1'b0);
    chk("rst_rdata", HRDATA,    32'h0);
    chk("rst_fault", FAULT,     8'h00);
    chk("rst_errc",  ERR_COUNT, 8'h00);
    step(); HRESET = 1'b0;
    step();

    // Hit read to slot 2 with one wait cycle.
    HADDR = 32'h0200_0010; HTRANS = 2'b10;
    at_neg(); chk("rd_hsel", HSEL_A, 8'h04);
    step(); HADDR = 32'h0; HTRANS = 2'b00; HREADYOUT_A[2] = 1'b0;
    at_neg(); chk("rd_wait", HREADYOUT, 1'b0);
    step(); HREADYOUT_A[2] = 1'b1;
    at_neg();
    chk("rd_ready", HREADYOUT, 1'b1);
    chk("rd_data",  HRDATA,    32'hCAFE_0002);
    chk("rd_resp",  HRESP,     1'b0);
    step();

    // Unmapped: tag mismatch, then unpopulated slot 5.
    unmapped(32'h1000_0000, 1, "tag");
    unmapped(32'h0500_0000, 2, "slot5");

    // Timeout: slot 3 hangs.
    HADDR = 32'h0300_0000; HTRANS = 2'b10;
    step(); HADDR = 32'h0; HTRANS = 2'b00; HREADYOUT_A[3] = 1'b0;
    done_at = 0;
    for (int i = 1; i <= 20; i++) begin
      at_neg();
      if (HREADYOUT) begin done_at = i; break; end
      step();
    end
    chk("to_len",   done_at, TO + 2);
    chk("to_resp",  HRESP,   1'b1);
    step(); HREADYOUT_A[3] = 1'b1;
    at_neg(); chk("to_fault", FAULT, 8'h08); chk("to_errc", ERR_COUNT, 8'd3);
    step();
    unmapped(32'h0300_0000, 4, "faulted");

    // Race: slot 1 becomes ready in the cycle the watchdog would fire.
    HADDR = 32'h0100_0000; HTRANS = 2'b10;
    step(); HADDR = 32'h0; HTRANS = 2'b00; HREADYOUT_A[1] = 1'b0;
    repeat (TO - 1) step();
    HREADYOUT_A[1] = 1'b1;
    at_neg(); chk("race_ready", HREADYOUT, 1'b1); chk("race_resp", HRESP, 1'b0);
    chk("race_data", HRDATA, 32'hCAFE_0001);
    step();
    at_neg(); chk("race_fault", FAULT, 8'h08); chk("race_errc", ERR_COUNT, 8'd4);
    step();

    // Pipelined writes: slot 0, slot 1, default, slot 0.
    HADDR = 32'h0000_0100; HTRANS = 2'b10;
    at_neg(); chk("pl_hsel0", HSEL_A, 8'h01);
    step(); HADDR = 32'h0100_0200;
    at_neg(); chk("pl_hsel1", HSEL_A, 8'h02);
    step(); HADDR = 32'h1000_0000;
    at_neg(); chk("pl_hseld", HSEL_A, 8'h00);
    step(); HADDR = 32'h0000_0300;
    at_neg(); chk("pl_wait", HREADYOUT, 1'b0);
    step();
    at_neg(); chk("pl_e2", {HREADYOUT, HRESP}, 2'b11);
    step(); HADDR = 32'h0; HTRANS = 2'b00;
    at_neg(); chk("pl_last", {HREADYOUT, HRESP}, 2'b10);
    step();
    at_neg(); chk("pl_errc", ERR_COUNT, 8'd5);
    step();

    // Reset during a stalled transfer.
    HADDR = 32'h0200_0000; HTRANS = 2'b10;
    step(); HADDR = 32'h0; HTRANS = 2'b00; HREADYOUT_A[2] = 1'b0;
    at_neg(); chk("mr_stall", HREADYOUT, 1'b0);
    step(); HRESET = 1'b1;
    at_neg();
    chk("mr_ready", HREADYOUT, 1'b1);
    chk("mr_fault", FAULT,     8'h00);
    chk("mr_errc",  ERR_COUNT, 8'h00);
    step(); HRESET = 1'b0; HREADYOUT_A[2] = 1'b1;
    at_neg(); chk("mr_after", HREADYOUT, 1'b1);
    step();
    repeat (2) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb_lite_interconnect.md
# ahb_lite_interconnect

Parametrised AHB-Lite single-master interconnect: address decoder, registered data-phase slave multiplexer, built-in default slave and per-slot bus watchdog in one block. It sits between the core's AHB-Lite master port and 2**DEVICES_EXP peripheral slots. It generalises the fixed decoder/slave-mux pair by adding:
- configurable slot count and decode window
- ERROR responses for unmapped addresses
- timeout abort of hung slaves, with sticky fault isolation

## Interface
Parameters:
- DEVICES_EXP, 3, log2 of slot count; N = 2**DEVICES_EXP
- DEC_LSB, 24, slot index = HADDR[DEC_LSB+DEVICES_EXP-1:DEC_LSB]
- BASE_TAG, 0, required value of HADDR[31:DEC_LSB+DEVICES_EXP]
- SLOT_EN, all ones (N bits), bit k = 1 means slot k is populated
- TIMEOUT, 255, maximum consecutive slave stall cycles before abort; 0 disables the watchdog

Ports:
- HCLK  in  1  bus clock
- HRESET  in  1  asynchronous, active-high reset
- HADDR  in  32  master address (address phase)
- HTRANS  in  2  master transfer type
- HSEL_A  out  N  one-hot slot select (address phase, combinational)
- HREADYOUT_A  in  N  per-slot ready
- HRESP_A  in  N  per-slot response
- HRDATA_A  in  N*32  per-slot read data; slot k occupies [32k+31:32k]
- HREADYOUT  out  1  system HREADY, fed back to master and all slots
- HRESP  out  1  system response
- HRDATA  out  32  system read data
- FAULT  out  N  sticky per-slot timeout flags
- ERR_COUNT  out  8  saturating count of interconnect-generated ERROR completions

## Operation
- Decode (combinational) on every cycle. Slot k is hit when all of:
  - HADDR[31:DEC_LSB+DEVICES_EXP] == BASE_TAG
  - the index field equals k
  - SLOT_EN[k] = 1
  - FAULT[k] = 0
- HSEL_A[k] is asserted on a hit, independent of HTRANS. No hit means no bit set, and the default slave is selected.
- Data-phase register: when HREADYOUT = 1, capture:
  - the slot index
  - a hit/default flag
  - an active flag = HTRANS[1] (NONSEQ or SEQ)
- FSM states: DATA, ERR1, ERR2.
- DATA, inactive phase (IDLE/BUSY): HREADYOUT=1, HRESP=0, HRDATA=0. Slot outputs are ignored.
- DATA, active phase, hit slot s:
  - HREADYOUT/HRESP/HRDATA pass through from slot s.
  - Slave ERROR responses are passed through unchanged.
- DATA, active phase, default slave:
  - HREADYOUT=0, HRESP=1, then go to ERR1 next cycle.
  - Equivalently, the default phase is presented as ERR1 immediately (see Timing).
- Watchdog:
  - A stall counter clears at each data-phase capture and increments each DATA cycle in which slot s drives HREADYOUT_A[s]=0.
  - When the counter equals TIMEOUT and HREADYOUT_A[s] is still 0, go to ERR1 and set FAULT[s].
  - If the slave asserts ready in that same cycle, the slave wins: normal completion, no fault.
- ERR1: HREADYOUT=0, HRESP=1, HRDATA=0; go to ERR2.
- ERR2: HREADYOUT=1, HRESP=1, HRDATA=0; ERR_COUNT increments (saturates at 255); go to DATA.
- FAULT bits are cleared only by HRESET. Once a slot is faulted, later accesses to it decode to the default slave.
- Outputs during ERR1/ERR2 never depend on HREADYOUT_A of the aborted slot.

## Timing
- Reset values:
  - state DATA; data phase inactive
  - HREADYOUT=1, HRESP=0, HRDATA=0
  - FAULT=0, ERR_COUNT=0, stall counter 0
- Zero added latency for hit slots: data-phase outputs are combinational from the registered select.
- Default-slave transfer: exactly 2 data-phase cycles (ERR1, ERR2). The state register loads ERR1 at capture when the captured phase is active and not a hit.
- Timeout abort: the transfer completes TIMEOUT+2 cycles after the data phase starts, counted as TIMEOUT stall cycles plus ERR1 plus ERR2.
- FAULT[s] is visible from the ERR1 cycle onward. An address phase issued during ERR2 to slot s therefore already decodes to default.
- Back-to-back pipelining: a new address phase is accepted only on cycles with HREADYOUT=1 (DATA with ready, or ERR2).
- HRESET asserted mid-transfer: immediate return to reset values; any slave in progress is abandoned.

## Test plan
- Reset: hold HRESET 3 cycles then release → HREADYOUT=1, HRESP=0, FAULT=0, ERR_COUNT=0.
- Hit read: NONSEQ read of 0x0200_0010 (DEVICES_EXP=3, DEC_LSB=24, BASE_TAG=0); slot 2 returns 0xCAFE_0002 after 1 wait cycle → HSEL_A=0x04 in the address phase; one low-ready cycle, then HRDATA=0xCAFE_0002, HRESP=0.
- Unmapped access, either of:
  - NONSEQ to 0x1000_0000 (tag mismatch)
  - NONSEQ to slot 5 with SLOT_EN[5]=0

  → HSEL_A=0; ERR1 (ready 0, resp 1), then ERR2 (ready 1, resp 1); ERR_COUNT=1.
- Timeout (TIMEOUT=4): slot 3 holds ready low indefinitely → 4 stall cycles, ERR1, ERR2; FAULT=0x08. A later access to slot 3 → HSEL_A=0, two-cycle ERROR.
- Race: slot 1 asserts ready exactly when the counter equals TIMEOUT → OKAY completion, FAULT[1]=0.
- Pipelined traffic: back-to-back NONSEQ writes to slots 0, 1, default, 0 → each data phase routed to the correct slot. The default transfer inserts one wait cycle. ERR_COUNT increments by exactly 1.
